// File: rtl/restoring_divider_pkg.sv
// restoring_divider_pkg: shared FSM encodings and default width for the restoring divider
package restoring_divider_pkg;
  localparam int DEFAULT_N = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
endpackage

// File: rtl/restoring_divider_sub_stage.sv
// sub_stage: unsigned trial subtractor producing difference and borrow
module sub_stage #(
  parameter int w = 9
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  output logic [w-1:0] diff,
  output logic         borrowout
);
  assign {borrowout, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/restoring_divider.sv
// restoring_divider: sequential unsigned divider, one quotient bit per clock with start/done handshake
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int n = DEFAULT_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] Q,
  output logic [n-1:0] R,
  output logic         divzero
);
  localparam int CW = $clog2(n + 1);
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [n-1:0]  d;
  logic [n:0]    trial;
  logic [n:0]    diff;
  logic          borrow;
  logic          unused_msb;
  assign trial = {R, Q[n-1]};
  sub_stage #(.w(n + 1)) u_sub (
    .a         (trial),
    .b         ({1'b0, d}),
    .diff      (diff),
    .borrowout (borrow)
  );
  assign unused_msb = diff[n];
  assign busy = state == S_RUN;
  assign done = state == S_DONE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      d       <= '0;
      Q       <= '0;
      R       <= '0;
      divzero <= 1'b0;
    end else if (state == S_IDLE) begin
      if (start && Y != '0) begin
        Q       <= X;
        d       <= Y;
        R       <= '0;
        count   <= CW'(n);
        divzero <= 1'b0;
        state   <= S_RUN;
      end else if (start) begin
        Q       <= '1;
        R       <= X;
        divzero <= 1'b1;
        state   <= S_DONE;
      end
    end else if (state == S_RUN) begin
      R     <= borrow ? trial[n-1:0] : diff[n-1:0];
      Q     <= {Q[n-2:0], ~borrow};
      count <= count - 1'b1;
      state <= (count == CW'(1)) ? S_DONE : S_RUN;
    end else begin
      state <= S_IDLE;
    end
  end
endmodule

// File: tb/tb_restoring_divider.sv
// tb_restoring_divider: scoreboard bench with random sweep against an arithmetic reference
module tb_restoring_divider;
  localparam int N = 8;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [N-1:0] X = '0;
  logic [N-1:0] Y = '0;
  logic         busy, done, divzero;
  logic [N-1:0] Q, R;
  typedef struct {
    int x;
    int y;
    int q;
    int r;
    int dz;
  } exp_t;
  exp_t sb[$];
  exp_t me;
  int checks = 0;
  int errors = 0;
  int dones = 0;

  restoring_divider #(.n(N)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .X       (X),
    .Y       (Y),
    .busy    (busy),
    .done    (done),
    .Q       (Q),
    .R       (R),
    .divzero (divzero)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int x, input int y);
    exp_t e;
    e.x = x;
    e.y = y;
    e.dz = (y == 0) ? 1 : 0;
    e.q = (y == 0) ? (1 << N) - 1 : x / y;
    e.r = (y == 0) ? x : x % y;
    return e;
  endfunction

  always @(negedge clock) begin
    if (!reset && done) begin
      dones++;
      chk("busy_at_done", busy, 0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        me = sb.pop_front();
        chk("Q", Q, me.q);
        chk("R", R, me.r);
        chk("divzero", divzero, me.dz);
        if (me.y != 0) begin
          chk("QY_plus_R", int'(Q) * me.y + int'(R), me.x);
          chk("R_lt_Y", int'(R) < me.y, 1);
        end
      end
    end
  end

  task automatic issue(input int x, input int y);
    X = N'(x);
    Y = N'(y);
    start = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!done && cyc < 50);
    chk("done_seen", done, 1);
  endtask

  task automatic run(input int x, input int y);
    int cyc = 1;
    int bz;
    issue(x, y);
    bz = busy ? 1 : 0;
    while (!done && cyc < 50) begin
      @(negedge clock);
      cyc++;
      if (busy) bz++;
    end
    chk("done_seen", done, 1);
    chk("latency", cyc, (y == 0) ? 1 : N + 1);
    chk("busy_cycles", bz, (y == 0) ? 0 : N);
    @(negedge clock);
  endtask

  initial begin
    int d0;
    #12;
    chk("rst_Q", Q, 0);
    chk("rst_R", R, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_divzero", divzero, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run(200, 7);
    run(255, 1);
    run(5, 9);
    run(9, 9);
    run(17, 0);
    run(0, 37);
    run(255, 255);
    // abandon a division mid-flight with an asynchronous reset
    issue(100, 3);
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("arst_Q", Q, 0);
    chk("arst_R", R, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_divzero", divzero, 0);
    sb.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    run(100, 3);
    d0 = dones;
    issue(90, 4);
    repeat (2) @(negedge clock);
    X = 8'd50;
    Y = 8'd6;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clock);
    chk("single_done_pulse", dones - d0, 1);
    X = 8'd60;
    Y = 8'd7;
    start = 1'b1;
    sb.push_back(model(60, 7));
    wait_done();
    X = 8'd13;
    Y = 8'd13;
    sb.push_back(model(13, 13));
    @(negedge clock);
    chk("held_idle_gap", busy, 0);
    @(negedge clock);
    chk("held_second_accepted", busy, 1);
    start = 1'b0;
    wait_done();
    @(negedge clock);
    repeat (40) begin
      int x = int'($urandom_range(0, 255));
      int sel = int'($urandom_range(0, 9));
      int y = (sel == 0) ? 0 : (sel < 4) ? int'($urandom_range(1, 15)) : int'($urandom_range(1, 255));
      run(x, y);
    end
    repeat (3) @(negedge clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
